// File: rtl/wide_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq_pkg
// Brief    : Shared state encoding and slice width for the sequential adder.
// Revision : 1.0 - initial release
// ============================================================================
package wide_add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wide_add_seq_rca.sv
`default_nettype none
// ============================================================================
// Module   : rca
// Brief    : 4-bit ripple-carry adder slice shared across all nibbles.
// Revision : 1.0 - initial release
// ============================================================================
module rca
    import wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] Sum,
    output logic               Cout
);

    // The carry chain is a local variable so the ripple stays inside one process.
    always_comb begin
        logic [SLICE_W:0] w_c;
        w_c    = '0;
        Sum    = '0;
        w_c[0] = Cin;
        for (int i = 0; i < SLICE_W; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
        end
        Cout = w_c[SLICE_W];
    end

endmodule
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Brief    : Multi-cycle WORDS-nibble adder/subtractor on one shared 4-bit rca.
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       Sub,
    input  logic [SLICE_W*WORDS-1:0]   A,
    input  logic [SLICE_W*WORDS-1:0]   B,
    input  logic                       Cin,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*WORDS-1:0]   Sum,
    output logic                       Cout,
    output logic                       V
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORDS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_sub;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_v;

    logic               w_accept;
    logic               w_last;
    logic [SLICE_W-1:0] w_sa;
    logic [SLICE_W-1:0] w_sb;
    logic [SLICE_W-1:0] w_ss;
    logic               w_sc;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_idx == c_last_idx);

    // Subtraction is A + ~B + 1 with the borrow-in folded into the initial carry.
    assign w_sa = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_sb = r_b[r_idx*SLICE_W +: SLICE_W] ^ {SLICE_W{r_sub}};

    rca u_rca (
        .A    (w_sa),
        .B    (w_sb),
        .Cin  (r_carry),
        .Sum  (w_ss),
        .Cout (w_sc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= Sub;
            r_carry <= Cin ^ Sub;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*SLICE_W +: SLICE_W] <= w_ss;
            r_carry <= w_sc;
            if (w_last) begin
                r_cout <= w_sc;
                r_v    <= (r_a[W-1] ~^ w_sb[SLICE_W-1]) & (r_a[W-1] ^ w_ss[SLICE_W-1]);
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign V    = r_v;

endmodule
`default_nettype wire
